uart3_tx: RTL

Parametrised, buffered UART transmitter. It is the successor to the fixed-rate 8N1 transmitter. It adds a FIFO, a runtime baud divisor, a selectable parity mode and a selectable number of stop bits. It sits between the host/readout logic and the serial pad. The frame is sent LSB first, and idle is line-high.

---
 rtl/uart3_tx_if.sv | 12 +
 rtl/uart3_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart3_tx_if.sv
// Host-side write port of the buffered UART transmitter.
// The host drives data and the load strobe; the transmitter returns FIFO-not-full.
interface uart3_tx_if #(
   parameter int WIDTH = 8
) ();
   logic             ld_tx_data;
   logic [WIDTH-1:0] tx_data;
   logic             tx_ready;

   modport master (output ld_tx_data, output tx_data, input tx_ready);
   modport slave  (input ld_tx_data, input tx_data, output tx_ready);
endinterface

// File: rtl/uart3_tx.sv
// Buffered UART transmitter: FIFO, runtime baud divisor, parity mode, 1 or 2 stop bits.
// Frames go out LSB first; the line idles high.
module uart3_tx #(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   input  logic                 tx_enable,
   input  logic                 clr_overflow,
   uart3_tx_if.slave            host,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 tx_empty,
   output logic [CNT_WIDTH-1:0] fifo_count,
   output logic                 overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0]     LAST_C  = IDX_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 overflow_q, tx_ready_q, tx_empty_q;
   state_t               state_q;
   logic [DIV_WIDTH-1:0] div_q, cnt_q;
   logic [WIDTH-1:0]     shift_q;
   logic [IDX_W-1:0]     idx_q;
   logic [1:0]           pmode_q;
   logic                 two_stop_q, stop_idx_q, parity_q, tx_out_q, tx_busy_q;
   logic                 push_s, pop_s, bit_end_s, stop_end_s, idle_next_s;
   logic [WIDTH-1:0]     head_s;

   function automatic logic parity_bit(input logic [WIDTH-1:0] w, input logic [1:0] mode);
      case (mode)
         2'b01:   parity_bit = ^w;
         2'b10:   parity_bit = ~(^w);
         default: parity_bit = 1'b0;
      endcase
   endfunction

   // Handshake decode; a pop never frees a slot for a same-cycle write.
   always_comb begin
      head_s      = mem_q[rd_ptr_q];
      bit_end_s   = (cnt_q == div_q);
      stop_end_s  = (state_q == STOP) && bit_end_s && (stop_idx_q == two_stop_q);
      push_s      = host.ld_tx_data && (count_q != DEPTH_C);
      pop_s       = tx_enable && (count_q != {CNT_WIDTH{1'b0}}) &&
                    ((state_q == IDLE) || stop_end_s);
      idle_next_s = !pop_s && ((state_q == IDLE) || stop_end_s);
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else if (pop_s && !push_s) begin
         count_d = count_q - CNT_WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // FIFO storage, occupancy and sticky overflow (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_WIDTH{1'b0}};
         overflow_q <= 1'b0;
         tx_ready_q <= 1'b1;
         tx_empty_q <= 1'b1;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= host.tx_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (host.ld_tx_data && !push_s) begin
            overflow_q <= 1'b1;
         end else if (clr_overflow) begin
            overflow_q <= 1'b0;
         end
         count_q    <= count_d;
         tx_ready_q <= (count_d != DEPTH_C);
         tx_empty_q <= (count_d == {CNT_WIDTH{1'b0}}) && idle_next_s;
      end
   end

   // Frame FSM; config is latched on pop so mid-frame changes wait for the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_out_q   <= 1'b1;
         tx_busy_q  <= 1'b0;
         cnt_q      <= {DIV_WIDTH{1'b0}};
         div_q      <= {DIV_WIDTH{1'b0}};
         shift_q    <= {WIDTH{1'b0}};
         idx_q      <= {IDX_W{1'b0}};
         pmode_q    <= 2'b00;
         two_stop_q <= 1'b0;
         stop_idx_q <= 1'b0;
         parity_q   <= 1'b0;
      end else if (pop_s) begin
         state_q    <= START;
         tx_out_q   <= 1'b0;
         tx_busy_q  <= 1'b1;
         cnt_q      <= {DIV_WIDTH{1'b0}};
         div_q      <= baud_div;
         pmode_q    <= parity_mode;
         two_stop_q <= two_stop;
         shift_q    <= head_s;
         parity_q   <= parity_bit(head_s, parity_mode);
         idx_q      <= {IDX_W{1'b0}};
         stop_idx_q <= 1'b0;
      end else if ((state_q != IDLE) && !bit_end_s) begin
         cnt_q <= cnt_q + DIV_WIDTH'(1);
      end else begin
         cnt_q <= {DIV_WIDTH{1'b0}};
         case (state_q)
            IDLE: begin
               tx_out_q  <= 1'b1;
               tx_busy_q <= 1'b0;
            end
            START: begin
               state_q  <= DATA;
               tx_out_q <= shift_q[0];
               shift_q  <= shift_q >> 1;
               idx_q    <= {IDX_W{1'b0}};
            end
            DATA: begin
               if (idx_q == LAST_C) begin
                  if (pmode_q != 2'b00) begin
                     state_q  <= PARITY;
                     tx_out_q <= parity_q;
                  end else begin
                     state_q    <= STOP;
                     tx_out_q   <= 1'b1;
                     stop_idx_q <= 1'b0;
                  end
               end else begin
                  idx_q    <= idx_q + IDX_W'(1);
                  tx_out_q <= shift_q[0];
                  shift_q  <= shift_q >> 1;
               end
            end
            PARITY: begin
               state_q    <= STOP;
               tx_out_q   <= 1'b1;
               stop_idx_q <= 1'b0;
            end
            STOP: begin
               if (stop_end_s) begin
                  state_q   <= IDLE;
                  tx_busy_q <= 1'b0;
                  tx_out_q  <= 1'b1;
               end else begin
                  stop_idx_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               tx_busy_q <= 1'b0;
               tx_out_q  <= 1'b1;
            end
         endcase
      end
   end

   assign tx_out        = tx_out_q;
   assign tx_busy       = tx_busy_q;
   assign tx_empty      = tx_empty_q;
   assign fifo_count    = count_q;
   assign overflow      = overflow_q;
   assign host.tx_ready = tx_ready_q;
endmodule
